dram_rsp_assembler: RTL and testbench
=====================================

DRAM_RSP_ASSEMBLER -- requirements
Module: dram_rsp_assembler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, meaning the L2 byte-address width.
REQ-002 SHALL have parameter NUM_OF_BANKS, default 8, meaning the bank count; bank field width is clog2.
REQ-003 SHALL have parameter NUM_OF_ROWS, default 128, meaning the row count; row and offset field widths are clog2.
REQ-004 SHALL have parameter NUM_OF_COLS, default 8, meaning beats per line; col field width is clog2.
REQ-005 SHALL have parameter DATA_WIDTH, default 8, meaning the bits per beat.
REQ-006 SHALL have one clock and an asynchronous active-high reset: clk input 1 (rising edge), then rst input 1.
REQ-007 SHALL have beat_valid input 1 and beat_ready output 1, the DRAM read-beat handshake.
REQ-008 SHALL have beat_bank_id, beat_row_id, beat_col_id and beat_offset inputs at field widths, giving the beat's DRAM coordinates.
REQ-009 SHALL have beat_data input DATA_WIDTH, the beat payload.
REQ-010 SHALL have l2_rsp_valid output 1 and l2_rsp_ready input 1, the L2 response handshake.
REQ-011 SHALL have l2_rsp_address output ADDR_WIDTH, the recomposed line byte address.
REQ-012 SHALL have l2_rsp_data output DATA_WIDTH*NUM_OF_COLS, with col k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have l2_rsp_err output 1, the line integrity flag.

Function
REQ-014 SHALL implement the FSM states IDLE, COLLECT and HOLD.
REQ-015 SHALL drive beat_ready = (state != HOLD); no bypass, so one bubble cycle per line.
REQ-016 SHALL, in IDLE, capture bank/row/offset on an accepted beat, write the beat, set beat count to 1 and go to COLLECT (or HOLD when NUM_OF_COLS==1).
REQ-017 SHALL, in COLLECT, write each accepted beat and increment the count; the accept at count NUM_OF_COLS-1 goes to HOLD.
REQ-018 SHALL assert l2_rsp_valid exactly when in HOLD, one cycle after the final beat is accepted.
REQ-019 SHALL hold address, data and err stable in HOLD until l2_rsp_ready; valid&ready returns to IDLE next cycle.
REQ-020 SHALL compose l2_rsp_address = {offset[6:0] at [ADDR_WIDTH-1:ADDR_WIDTH-7], bank at [ADDR_WIDTH-8:ADDR_WIDTH-10], row at [ADDR_WIDTH-11:ADDR_WIDTH-17]}, all lower bits 0 (line base, col 0).
REQ-021 SHALL limit the beat counter to clog2(NUM_OF_COLS)+1 bits, with no wrap beyond NUM_OF_COLS.
REQ-022 SHALL have no effect from beat_valid=0 in IDLE/COLLECT; a line may stall indefinitely with no timeout.

Reset
REQ-023 SHALL, on rst asserted (asynchronously), force state=IDLE, count=0, l2_rsp_valid=0, l2_rsp_err=0, l2_rsp_address=0, l2_rsp_data=0 and beat_ready=1 after reset.
REQ-024 SHALL discard a partially collected or held line on reset mid-operation, with no response emitted.

Configuration
REQ-025 SHALL, with DRAM_RSP_ORDER_CHECK_EN defined, write each beat at the expected index (count) and set err for the line if beat_col_id != count or bank/row/offset differ from the captured values.
REQ-026 SHALL, with DRAM_RSP_ORDER_CHECK_EN defined, clear err on entry to IDLE.
REQ-027 SHALL, without DRAM_RSP_ORDER_CHECK_EN, write each beat at index beat_col_id, tie l2_rsp_err to 0 and omit the compare logic.

Structure
REQ-028 SHALL place the FSM state enum, the address field-position constants and the default geometry in the shared package dram_pkg, which dram_addr_translator also uses.
REQ-029 SHALL implement address composition in sub-module dram_addr_composer, the combinational inverse of the translator's field split.

Verification
REQ-030 SHALL check in-order line: beats col 0..7, bank=3, row=0x15, offset=0x01, data 0x10..0x17 -> valid 1 cycle after beat 7, address=0x02CA8, data=0x1716151413121110, err=0.
REQ-031 SHALL check backpressure: l2_rsp_ready low for 5 cycles in HOLD -> outputs stable, beat_ready=0 throughout; accept -> beat_ready=1 next cycle.
REQ-032 SHALL check back-to-back lines: two lines with beat_valid held high -> exactly one bubble cycle between lines, both responses correct.
REQ-033 SHALL check order error with macro defined: col sequence 0,1,3,2,... -> err=1 on that line and err=0 on the following clean line; without the macro, data lands by col_id and err=0.
REQ-034 SHALL check field mismatch with macro defined: beat 4 has bank=5 where line bank=3 -> err=1, address uses bank 3.
REQ-035 SHALL check reset mid-line: rst after 3 beats -> no response, next full line assembles correctly.

Source files
------------

// File: rtl/dram_pkg.sv
// -----------------------------------------------------------------------------
// dram_pkg -- shared definitions for the DRAM read path.
//
// Holds the response-assembler FSM state type, the default DRAM geometry and
// the fixed positions of the offset/bank/row fields inside an L2 byte address.
// The positions are measured down from the address MSB, so they apply to any
// ADDR_WIDTH of at least 17 bits. dram_addr_translator splits an address with
// these constants and dram_addr_composer joins the fields back together.
// -----------------------------------------------------------------------------
package dram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } rsp_state_e;

  // Default geometry
  localparam int DEF_ADDR_WIDTH   = 20;
  localparam int DEF_NUM_OF_BANKS = 8;
  localparam int DEF_NUM_OF_ROWS  = 128;
  localparam int DEF_NUM_OF_COLS  = 8;
  localparam int DEF_DATA_WIDTH   = 8;

  // Address fields: width and distance of the field MSB below the address MSB
  localparam int OFFSET_FLD_W  = 7;
  localparam int OFFSET_FLD_HI = 0;
  localparam int BANK_FLD_W    = 3;
  localparam int BANK_FLD_HI   = 7;
  localparam int ROW_FLD_W     = 7;
  localparam int ROW_FLD_HI    = 10;

  // Field width for a count of n items; never narrower than one bit.
  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_addr_composer.sv
// -----------------------------------------------------------------------------
// dram_addr_composer -- rebuilds an L2 line base address from DRAM coordinates.
//
// This is the combinational inverse of the translator's field split: the
// offset, bank and row fields go to their fixed positions below the MSB. All
// bits below the row field (the column/byte part) are zero, so the result is
// the line base address.
//
// Ports:
//   bank   [BANK_W-1:0]     bank coordinate
//   row    [ROW_W-1:0]      row coordinate
//   offset [OFFSET_W-1:0]   offset coordinate
//   addr   [ADDR_WIDTH-1:0] composed line byte address
// -----------------------------------------------------------------------------
module dram_addr_composer
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BANK_W     = 3,
  parameter int ROW_W      = 7,
  parameter int OFFSET_W   = 7
) (
  input  logic [BANK_W-1:0]     bank,
  input  logic [ROW_W-1:0]      row,
  input  logic [OFFSET_W-1:0]   offset,
  output logic [ADDR_WIDTH-1:0] addr
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    addr = '0;
    addr[ADDR_WIDTH-1-OFFSET_FLD_HI -: OFFSET_FLD_W] = OFFSET_FLD_W'(offset);
    addr[ADDR_WIDTH-1-BANK_FLD_HI   -: BANK_FLD_W]   = BANK_FLD_W'(bank);
    addr[ADDR_WIDTH-1-ROW_FLD_HI    -: ROW_FLD_W]    = ROW_FLD_W'(row);
  end

endmodule

// File: rtl/dram_rsp_assembler.sv
// -----------------------------------------------------------------------------
// dram_rsp_assembler -- collects NUM_OF_COLS DRAM read beats into one L2 line.
//
// The first beat of a line fixes its bank/row/offset. Beats are stored into a
// line buffer. When the last beat has been accepted the line is presented on
// the L2 response port and held there until l2_rsp_ready. beat_ready is low
// while a response is held, so each line costs one bubble cycle.
//
// Optional feature (define DRAM_RSP_ORDER_CHECK_EN):
//   beats are stored by arrival order, and l2_rsp_err flags a line whose
//   column ids are out of order or whose bank/row/offset change mid-line.
//   When the macro is undefined, beats are stored at beat_col_id and
//   l2_rsp_err is tied low.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   beat_valid / beat_ready      DRAM read-beat handshake
//   beat_bank_id/row_id/col_id   DRAM coordinates of the beat
//   beat_offset                  offset coordinate of the beat
//   beat_data   [DATA_WIDTH-1:0] beat payload
//   l2_rsp_valid / l2_rsp_ready  L2 response handshake
//   l2_rsp_address               line base byte address
//   l2_rsp_data                  line data, col k at [k*DATA_WIDTH +: DATA_WIDTH]
//   l2_rsp_err                   line integrity flag
// -----------------------------------------------------------------------------
module dram_rsp_assembler
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
  parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  localparam int BANK_W      = field_w(NUM_OF_BANKS),
  localparam int ROW_W       = field_w(NUM_OF_ROWS),
  localparam int COL_W       = field_w(NUM_OF_COLS),
  localparam int LINE_W      = DATA_WIDTH * NUM_OF_COLS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_valid,
  output logic                  beat_ready,
  input  logic [BANK_W-1:0]     beat_bank_id,
  input  logic [ROW_W-1:0]      beat_row_id,
  input  logic [COL_W-1:0]      beat_col_id,
  input  logic [ROW_W-1:0]      beat_offset,
  input  logic [DATA_WIDTH-1:0] beat_data,
  output logic                  l2_rsp_valid,
  input  logic                  l2_rsp_ready,
  output logic [ADDR_WIDTH-1:0] l2_rsp_address,
  output logic [LINE_W-1:0]     l2_rsp_data,
  output logic                  l2_rsp_err
);

  // One extra bit so the counter can represent NUM_OF_COLS itself
  localparam int CNT_W = $clog2(NUM_OF_COLS) + 1;

  rsp_state_e          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BANK_W-1:0]   line_bank_q;
  logic [ROW_W-1:0]    line_row_q;
  logic [ROW_W-1:0]    line_offset_q;
  logic [LINE_W-1:0]   line_data_q;
  logic [COL_W-1:0]    wr_idx;
  logic                beat_fire;
  logic                last_beat;

  assign beat_ready   = (state_q != HOLD);
  assign l2_rsp_valid = (state_q == HOLD);
  assign beat_fire    = beat_valid & beat_ready;
  assign last_beat    = (count_q == CNT_W'(NUM_OF_COLS - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (beat_fire) begin
          count_d = CNT_W'(1);
          state_d = (NUM_OF_COLS == 1) ? HOLD : COLLECT;
        end
      end
      COLLECT: begin
        if (beat_fire) begin
          count_d = count_q + CNT_W'(1);
          if (last_beat) state_d = HOLD;
        end
      end
      HOLD: begin
        if (l2_rsp_ready) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line buffer and captured coordinates
  // ---------------------------------------------------------------------------
`ifdef DRAM_RSP_ORDER_CHECK_EN
  // Beats land by arrival order; the column id is only checked, not trusted.
  assign wr_idx = COL_W'(count_q);
`else
  assign wr_idx = beat_col_id;
`endif

  // NOTE: the line buffer is reset even though it is plain storage, because
  // l2_rsp_data must read zero straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_data_q   <= '0;
      line_bank_q   <= '0;
      line_row_q    <= '0;
      line_offset_q <= '0;
    end else if (beat_fire) begin
      line_data_q[int'(wr_idx) * DATA_WIDTH +: DATA_WIDTH] <= beat_data;
      if (state_q == IDLE) begin
        line_bank_q   <= beat_bank_id;
        line_row_q    <= beat_row_id;
        line_offset_q <= beat_offset;
      end
    end
  end

  assign l2_rsp_data = line_data_q;

`ifdef DRAM_RSP_ORDER_CHECK_EN
  logic err_q;
  logic beat_mismatch;

  // The first beat only has its column checked; later beats must also repeat
  // the coordinates captured from the first one.
  assign beat_mismatch = (CNT_W'(beat_col_id) != count_q) ||
                         ((state_q != IDLE) &&
                          ((beat_bank_id != line_bank_q) ||
                           (beat_row_id  != line_row_q)  ||
                           (beat_offset  != line_offset_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == HOLD) && l2_rsp_ready) begin
      err_q <= 1'b0;
    end else if (beat_fire) begin
      err_q <= ((state_q == IDLE) ? 1'b0 : err_q) | beat_mismatch;
    end
  end

  assign l2_rsp_err = err_q;
`else
  assign l2_rsp_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Address recomposition
  // ---------------------------------------------------------------------------
  dram_addr_composer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BANK_W     (BANK_W),
    .ROW_W      (ROW_W),
    .OFFSET_W   (ROW_W)
  ) u_addr_composer (
    .bank   (line_bank_q),
    .row    (line_row_q),
    .offset (line_offset_q),
    .addr   (l2_rsp_address)
  );

endmodule

// File: tb/tb_dram_rsp_assembler.sv
// -----------------------------------------------------------------------------
// tb_dram_rsp_assembler -- self-checking bench for dram_rsp_assembler.
//
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A reference model turns each line of beats into the expected
// response. A monitor pops those expectations whenever a response handshake
// happens. Directed lines cover the named scenarios, followed by randomized
// lines with input gaps, response stalls, shuffled columns and the occasional
// bad bank.
// -----------------------------------------------------------------------------
module tb_dram_rsp_assembler;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int NC = 8;

`ifdef DRAM_RSP_ORDER_CHECK_EN
  localparam bit ORDER_CHK = 1'b1;
`else
  localparam bit ORDER_CHK = 1'b0;
`endif

  typedef struct {
    logic [2:0] bank;
    logic [6:0] row;
    logic [6:0] off;
    logic [2:0] col;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [DW*NC-1:0] data;
    logic            err;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            beat_valid;
  logic            beat_ready;
  logic [2:0]      beat_bank_id;
  logic [6:0]      beat_row_id;
  logic [2:0]      beat_col_id;
  logic [6:0]      beat_offset;
  logic [DW-1:0]   beat_data;
  logic            l2_rsp_valid;
  logic            l2_rsp_ready;
  logic [AW-1:0]   l2_rsp_address;
  logic [DW*NC-1:0] l2_rsp_data;
  logic            l2_rsp_err;

  int              vectors     = 0;
  int              miscompares = 0;
  int              bubbles     = 0;
  rsp_t            exp_q[$];
  logic [DW*NC-1:0] model_line = '0;
  beat_t           ln[NC];
  beat_t           ln2[NC];

  always #5 clk = ~clk;

  dram_rsp_assembler #(
    .ADDR_WIDTH   (AW),
    .NUM_OF_BANKS (8),
    .NUM_OF_ROWS  (128),
    .NUM_OF_COLS  (NC),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .beat_valid     (beat_valid),
    .beat_ready     (beat_ready),
    .beat_bank_id   (beat_bank_id),
    .beat_row_id    (beat_row_id),
    .beat_col_id    (beat_col_id),
    .beat_offset    (beat_offset),
    .beat_data      (beat_data),
    .l2_rsp_valid   (l2_rsp_valid),
    .l2_rsp_ready   (l2_rsp_ready),
    .l2_rsp_address (l2_rsp_address),
    .l2_rsp_data    (l2_rsp_data),
    .l2_rsp_err     (l2_rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: address from the first beat's fields, data by arrival
  // order (order check on) or by column id (order check off).
  task automatic predict(input beat_t b[NC], output rsp_t r);
    int idx;
    r.addr = (AW'(b[0].off) << 13) | (AW'(b[0].bank) << 10) | (AW'(b[0].row) << 3);
    r.err  = 1'b0;
    for (int i = 0; i < NC; i++) begin
      idx = ORDER_CHK ? i : int'(b[i].col);
      model_line[idx*DW +: DW] = b[i].data;
      if (ORDER_CHK && ((int'(b[i].col) != i) || (b[i].bank != b[0].bank) ||
                        (b[i].row != b[0].row) || (b[i].off != b[0].off)))
        r.err = 1'b1;
    end
    r.data = model_line;
  endtask

  task automatic make_line(input logic [2:0] bank, input logic [6:0] row,
                           input logic [6:0] off, input logic [7:0] base,
                           output beat_t b[NC]);
    for (int i = 0; i < NC; i++) begin
      b[i].bank = bank;
      b[i].row  = row;
      b[i].off  = off;
      b[i].col  = 3'(i);
      b[i].data = base + 8'(i);
    end
  endtask

  // Response monitor: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rst === 1'b0) begin
      if (beat_valid && !beat_ready) bubbles++;
      if (l2_rsp_valid && l2_rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(l2_rsp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_addr", 64'(l2_rsp_address), 64'(e.addr));
          check("rsp_data", l2_rsp_data, e.data);
          check("rsp_err",  64'(l2_rsp_err), 64'(e.err));
        end
      end
    end
  end

  // Present one beat (after an optional idle gap) and return 1 unit after the
  // edge that accepted it.
  task automatic send_beat(input beat_t b, input int gap);
    if (gap > 0) begin
      beat_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    beat_valid   = 1'b1;
    beat_bank_id = b.bank;
    beat_row_id  = b.row;
    beat_col_id  = b.col;
    beat_offset  = b.off;
    beat_data    = b.data;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (beat_ready) break;
      if (t > 40) begin
        check("beat_ready_timeout", 64'(beat_ready), 64'(1));
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_line(input beat_t b[NC], input int stall,
                           input bit keep_valid, input bit gaps);
    rsp_t e;
    predict(b, e);
    exp_q.push_back(e);
    l2_rsp_ready = (stall == 0);
    for (int i = 0; i < NC; i++)
      send_beat(b[i], gaps ? int'($urandom_range(0, 2)) : 0);
    if (!keep_valid) beat_valid = 1'b0;
    @(negedge clk);
    check("valid_latency", 64'(l2_rsp_valid), 64'(1));
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        if (s > 0) @(negedge clk);
        check("hold_valid",      64'(l2_rsp_valid), 64'(1));
        check("hold_beat_ready", 64'(beat_ready), 64'(0));
        check("hold_addr",       64'(l2_rsp_address), 64'(e.addr));
        check("hold_data",       l2_rsp_data, e.data);
        check("hold_err",        64'(l2_rsp_err), 64'(e.err));
        @(posedge clk); #1;
      end
      l2_rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("ready_after_accept", 64'(beat_ready), 64'(1));
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    beat_valid   = 1'b0;
    beat_bank_id = '0;
    beat_row_id  = '0;
    beat_col_id  = '0;
    beat_offset  = '0;
    beat_data    = '0;
    l2_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",      64'(l2_rsp_valid), 64'(0));
    check("rst_beat_ready", 64'(beat_ready), 64'(1));
    check("rst_addr",       64'(l2_rsp_address), 64'(0));
    check("rst_data",       l2_rsp_data, 64'(0));
    check("rst_err",        64'(l2_rsp_err), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // In-order line: bank 3, row 0x15, offset 1, data 0x10..0x17
    make_line(3'd3, 7'h15, 7'h01, 8'h10, ln);
    send_line(ln, 0, 1'b0, 1'b0);

    // Backpressure: response held for 5 cycles
    make_line(3'd6, 7'h2A, 7'h55, 8'hA0, ln);
    send_line(ln, 5, 1'b0, 1'b0);

    // Back-to-back lines with beat_valid held high: one bubble in between
    bubbles = 0;
    make_line(3'd1, 7'h7F, 7'h00, 8'h30, ln);
    make_line(3'd7, 7'h00, 7'h7F, 8'hC8, ln2);
    send_line(ln, 0, 1'b1, 1'b0);
    send_line(ln2, 0, 1'b0, 1'b0);
    check("b2b_bubbles", 64'(bubbles), 64'(1));

    // Column order 0,1,3,2,4.. then a clean line
    make_line(3'd2, 7'h11, 7'h22, 8'h40, ln);
    ln[2].col = 3'd3;
    ln[3].col = 3'd2;
    send_line(ln, 0, 1'b0, 1'b0);
    make_line(3'd2, 7'h12, 7'h22, 8'h50, ln);
    send_line(ln, 0, 1'b0, 1'b0);

    // Beat 4 carries bank 5 on a bank-3 line
    make_line(3'd3, 7'h15, 7'h01, 8'h60, ln);
    ln[4].bank = 3'd5;
    send_line(ln, 1, 1'b0, 1'b0);

    // Reset after 3 beats: nothing emitted, next line assembles cleanly
    make_line(3'd4, 7'h33, 7'h44, 8'h70, ln);
    for (int i = 0; i < 3; i++) send_beat(ln[i], 0);
    beat_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("midrst_valid",      64'(l2_rsp_valid), 64'(0));
    check("midrst_beat_ready", 64'(beat_ready), 64'(1));
    check("midrst_data",       l2_rsp_data, 64'(0));
    check("midrst_addr",       64'(l2_rsp_address), 64'(0));
    check("midrst_err",        64'(l2_rsp_err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_line = '0;
    @(posedge clk); #1;
    make_line(3'd5, 7'h0F, 7'h3C, 8'h80, ln);
    send_line(ln, 0, 1'b0, 1'b0);

    // Randomized lines
    for (int n = 0; n < 24; n++) begin
      int j;
      logic [2:0] tmp;
      make_line(3'($urandom), 7'($urandom), 7'($urandom), 8'($urandom), ln);
      for (int i = 0; i < NC; i++) ln[i].data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = NC - 1; i > 0; i--) begin
          j = int'($urandom_range(0, i));
          tmp = ln[i].col;
          ln[i].col = ln[j].col;
          ln[j].col = tmp;
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        j = int'($urandom_range(1, NC - 1));
        ln[j].bank = ln[j].bank + 3'd1;
      end
      send_line(ln, int'($urandom_range(0, 3)), 1'b0, 1'b1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
